// File: rtl/enc_pkg.sv
// Shared encoder package: RD constants, UV mode encoding, score type and
// the mode-decision FSM state encoding.
package enc_pkg;

   localparam int unsigned RD_DISTO_MULT_SHIFT = 8;

   localparam int unsigned UV_NUM_MODES = 4;
   localparam int unsigned UV_LAMBDA_W  = 16;
   localparam int unsigned UV_SCORE_W   = 64;

   localparam int unsigned RATE_W  = 32;
   localparam int unsigned HDR_W   = 16;
   localparam int unsigned DISTO_W = 32;

   typedef enum logic [1:0] {
      UV_DC = 2'd0,
      UV_TM = 2'd1,
      UV_V  = 2'd2,
      UV_H  = 2'd3
   } uv_mode_e;

   typedef logic [UV_SCORE_W-1:0] score_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2
   } uv_state_e;

endpackage

// File: rtl/rd_score_calc.sv
// Two-stage RD score pipeline: score = (R+H)*lambda + ((D+SD) << 8).
// Carries an opaque tag alongside each candidate; never stalls.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_flush          clears in-flight valids (abort)
//   i_valid          candidate enters S1
//   i_tag            sideband carried to the output (e.g. mode index)
//   i_r, i_h         rate and header cost
//   i_d, i_sd        distortion and spectral distortion
//   i_lambda         RD lambda used in S2
//   o_s1_valid       S1 register holds a candidate
//   o_valid          S2 result valid
//   o_tag, o_score   S2 result
module rd_score_calc
   import enc_pkg::*;
#(
   parameter int unsigned LAMBDA_W = UV_LAMBDA_W,
   parameter int unsigned SCORE_W  = UV_SCORE_W,
   parameter int unsigned TAG_W    = 2
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_flush,
   input  logic                i_valid,
   input  logic [TAG_W-1:0]    i_tag,
   input  logic [RATE_W-1:0]   i_r,
   input  logic [HDR_W-1:0]    i_h,
   input  logic [DISTO_W-1:0]  i_d,
   input  logic [DISTO_W-1:0]  i_sd,
   input  logic [LAMBDA_W-1:0] i_lambda,
   output logic                o_s1_valid,
   output logic                o_valid,
   output logic [TAG_W-1:0]    o_tag,
   output logic [SCORE_W-1:0]  o_score
);

   localparam int unsigned A_W = RATE_W + 1;
   localparam int unsigned B_W = DISTO_W + 1 + RD_DISTO_MULT_SHIFT;

   logic               r_v1;
   logic               r_v2;
   logic [A_W-1:0]     r_a;
   logic [B_W-1:0]     r_b;
   logic [TAG_W-1:0]   r_tag1;
   logic [TAG_W-1:0]   r_tag2;
   logic [SCORE_W-1:0] r_s;

   logic [DISTO_W:0]   w_dsum;
   logic [SCORE_W-1:0] w_prod;
   logic [SCORE_W-1:0] w_sum;

   assign w_dsum = (DISTO_W+1)'(i_d) + (DISTO_W+1)'(i_sd);
   assign w_prod = SCORE_W'(r_a) * SCORE_W'(i_lambda);
   assign w_sum  = w_prod + SCORE_W'(r_b);

   // Valid chain; flush drops whatever is in flight.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else begin
         r_v1 <= i_valid;
         r_v2 <= r_v1;
      end
   end

   // Datapath registers, loaded only with live data.
   always_ff @(posedge i_clk) begin
      if (i_valid) begin
         r_a    <= A_W'(i_r) + A_W'(i_h);
         r_b    <= B_W'(w_dsum) << RD_DISTO_MULT_SHIFT;
         r_tag1 <= i_tag;
      end
      if (r_v1) begin
         r_s    <= w_sum;
         r_tag2 <= r_tag1;
      end
   end

   assign o_s1_valid = r_v1;
   assign o_valid    = r_v2;
   assign o_tag      = r_tag2;
   assign o_score    = r_s;

endmodule

// File: rtl/uv_mode_select.sv
// Chroma intra-mode decision: collects NUM_MODES scored candidates per
// macroblock and reports the minimum-score mode (earliest wins ties).
// Optional feature macro: UV_SD_EN adds the i_cand_sd port and the SD term.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               new macroblock / abort; samples i_lambda
//   i_lambda              RD lambda
//   i_cand_valid/o_cand_ready  candidate handshake
//   i_cand_mode           mode tag, reported verbatim
//   i_cand_r/h/d(/sd)     rate, header cost, distortion(, spectral disto)
//   o_best_mode/score     winner, held after o_done
//   o_done                1-cycle pulse when the decision is complete
module uv_mode_select
   import enc_pkg::*;
#(
   parameter int unsigned NUM_MODES = UV_NUM_MODES,
   parameter int unsigned LAMBDA_W  = UV_LAMBDA_W,
   parameter int unsigned SCORE_W   = UV_SCORE_W
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic [LAMBDA_W-1:0] i_lambda,
   input  logic                i_cand_valid,
   output logic                o_cand_ready,
   input  logic [1:0]          i_cand_mode,
   input  logic [31:0]         i_cand_r,
   input  logic [15:0]         i_cand_h,
   input  logic [31:0]         i_cand_d,
`ifdef UV_SD_EN
   input  logic [31:0]         i_cand_sd,
`endif
   output logic [1:0]          o_best_mode,
   output logic [SCORE_W-1:0]  o_best_score,
   output logic                o_done
);

   localparam int unsigned CNT_W = $clog2(NUM_MODES + 1);

   uv_state_e          r_state;
   uv_state_e          w_next_state;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   w_next_count;
   logic [CNT_W-1:0]   w_count_inc;
   logic               r_cand_ready;
   logic               w_next_ready;
   logic               r_done;
   logic               w_next_done;
   logic [LAMBDA_W-1:0] r_lambda;
   logic               r_first;
   logic [1:0]         r_best_mode;
   logic [SCORE_W-1:0] r_best_score;

   logic               w_accept;
   logic [31:0]        w_sd;
   logic               w_s1_valid;
   logic               w_s2_valid;
   logic [1:0]         w_s2_mode;
   logic [SCORE_W-1:0] w_s2_score;

`ifdef UV_SD_EN
   assign w_sd = i_cand_sd;
`else
   assign w_sd = 32'd0;
`endif

   // Start wins over a coincident handshake.
   assign w_accept    = i_cand_valid & r_cand_ready & ~i_start;
   assign w_count_inc = r_count + CNT_W'(1);

   rd_score_calc #(
      .LAMBDA_W (LAMBDA_W),
      .SCORE_W  (SCORE_W),
      .TAG_W    (2)
   ) u_score (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_flush    (i_start),
      .i_valid    (w_accept),
      .i_tag      (i_cand_mode),
      .i_r        (i_cand_r),
      .i_h        (i_cand_h),
      .i_d        (i_cand_d),
      .i_sd       (w_sd),
      .i_lambda   (r_lambda),
      .o_s1_valid (w_s1_valid),
      .o_valid    (w_s2_valid),
      .o_tag      (w_s2_mode),
      .o_score    (w_s2_score)
   );

   // State, count and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_count      <= '0;
         r_cand_ready <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_count      <= w_next_count;
         r_cand_ready <= w_next_ready;
         r_done       <= w_next_done;
      end
   end

   // Next state; done is raised one cycle ahead so it lands with best_*.
   always_comb begin
      w_next_state = r_state;
      w_next_count = r_count;
      w_next_done  = 1'b0;
      if (i_start) begin
         w_next_state = ST_COLLECT;
         w_next_count = '0;
      end else begin
         case (r_state)
            ST_COLLECT: begin
               if (w_accept) begin
                  w_next_count = w_count_inc;
                  if (w_count_inc == CNT_W'(NUM_MODES)) begin
                     w_next_state = ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // Last candidate is in S2 and nothing follows it.
               if (w_s2_valid && !w_s1_valid) begin
                  w_next_state = ST_IDLE;
                  w_next_done  = 1'b1;
               end
            end
            default: begin
               w_next_state = ST_IDLE;
            end
         endcase
      end
      w_next_ready = (w_next_state == ST_COLLECT);
   end

   // Lambda is held for the whole macroblock.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lambda <= '0;
      end else if (i_start) begin
         r_lambda <= i_lambda;
      end
   end

   // Best tracking: first candidate loads, later ones need a strictly lower score.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_first      <= 1'b0;
         r_best_mode  <= 2'd0;
         r_best_score <= '0;
      end else if (i_start) begin
         r_first <= 1'b1;
      end else if (w_s2_valid) begin
         r_first <= 1'b0;
         if (r_first || (w_s2_score < r_best_score)) begin
            r_best_mode  <= w_s2_mode;
            r_best_score <= w_s2_score;
         end
      end
   end

   assign o_cand_ready = r_cand_ready;
   assign o_done       = r_done;
   assign o_best_mode  = r_best_mode;
   assign o_best_score = r_best_score;

endmodule

// File: tb/tb_uv_mode_select.sv
module tb_uv_mode_select;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] lambda;
   logic        cand_valid;
   logic        cand_ready;
   logic [1:0]  cand_mode;
   logic [31:0] cand_r;
   logic [15:0] cand_h;
   logic [31:0] cand_d;
   logic [31:0] cand_sd;
   logic [1:0]  best_mode;
   logic [63:0] best_score;
   logic        done;

   int n_total = 0;
   int n_bad   = 0;
   int n_done  = 0;
   int lat;
   int d0;

   always #5 clk = ~clk;

   uv_mode_select dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_lambda     (lambda),
      .i_cand_valid (cand_valid),
      .o_cand_ready (cand_ready),
      .i_cand_mode  (cand_mode),
      .i_cand_r     (cand_r),
      .i_cand_h     (cand_h),
      .i_cand_d     (cand_d),
`ifdef UV_SD_EN
      .i_cand_sd    (cand_sd),
`endif
      .o_best_mode  (best_mode),
      .o_best_score (best_score),
      .o_done       (done)
   );

   always @(negedge clk) begin
      if (done) n_done++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [15:0] lam);
      start  = 1'b1;
      lambda = lam;
      tick();
      start  = 1'b0;
   endtask

   task automatic send(input logic [1:0] m, input logic [31:0] r, input logic [15:0] h,
                       input logic [31:0] d, input logic [31:0] sd);
      cand_valid = 1'b1;
      cand_mode  = m;
      cand_r     = r;
      cand_h     = h;
      cand_d     = d;
      cand_sd    = sd;
      tick();
      cand_valid = 1'b0;
   endtask

   // Cycles after the last accept's sampling point until done is seen.
   task automatic wait_done(output int l);
      l = -1;
      for (int i = 1; i <= 12 && l < 0; i++) begin
         tick();
         if (done) l = i;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; lambda = '0; cand_valid = 1'b0;
      cand_mode = '0; cand_r = '0; cand_h = '0; cand_d = '0; cand_sd = '0;
      idle(3);
      check("rst_ready", 64'(cand_ready), 64'd0);
      check("rst_done",  64'(done),       64'd0);
      check("rst_mode",  64'(best_mode),  64'd0);
      check("rst_score", best_score,      64'd0);
      rst = 1'b0;
      tick();

      // Basic decision plus exact latency: accepts in cycles 0..3, done in cycle 6.
      pulse_start(16'd10);
      check("t1_ready", 64'(cand_ready), 64'd1);
      d0 = n_done;
      send(2'd0, 100, 20, 1000, 0);
      send(2'd1, 50, 10, 900, 0);
      send(2'd2, 0, 0, 2000, 0);
      send(2'd3, 0, 0, 2000, 0);
      check("t1_ready_drain", 64'(cand_ready), 64'd0);
      wait_done(lat);
      check("t1_latency", 64'(lat), 64'd2);
      check("t1_mode",  64'(best_mode), 64'd1);
      check("t1_score", best_score, 64'd231000);
      idle(4);
      check("t1_single_done", 64'(n_done - d0), 64'd1);
      check("t1_mode_held", 64'(best_mode), 64'd1);

      // Ties keep the first; valid while not ready is ignored; lambda=0.
      cand_valid = 1'b1; cand_mode = 2'd1; cand_d = 0; cand_r = 0; cand_h = 0;
      idle(2);
      check("t2_idle_ready", 64'(cand_ready), 64'd0);
      cand_valid = 1'b0;
      pulse_start(16'd0);
      send(2'd2, 7, 7, 20, 0);
      send(2'd0, 7, 7, 20, 0);
      send(2'd3, 7, 7, 20, 0);
      send(2'd1, 7, 7, 20, 0);
      wait_done(lat);
      check("t2_latency", 64'(lat), 64'd2);
      check("t2_mode",  64'(best_mode), 64'd2);
      check("t2_score", best_score, 64'd5120);

      // Abort after two accepts; the candidate coincident with start is dropped.
      idle(2);
      d0 = n_done;
      pulse_start(16'd1);
      send(2'd3, 0, 0, 1, 0);
      send(2'd3, 0, 0, 1, 0);
      start = 1'b1; lambda = 16'd1;
      cand_valid = 1'b1; cand_mode = 2'd1; cand_r = 0; cand_h = 0; cand_d = 0; cand_sd = 0;
      tick();
      start = 1'b0; cand_valid = 1'b0;
      send(2'd0, 0, 0, 500, 0);
      send(2'd1, 0, 0, 400, 0);
      send(2'd2, 0, 0, 300, 0);
      send(2'd3, 0, 0, 600, 0);
      wait_done(lat);
      check("t4_latency", 64'(lat), 64'd2);
      check("t4_mode",  64'(best_mode), 64'd2);
      check("t4_score", best_score, 64'd76800);
      idle(6);
      check("t4_one_done", 64'(n_done - d0), 64'd1);

      // Reset in DRAIN: no done, outputs cleared, no late done.
      pulse_start(16'd3);
      send(2'd0, 1, 1, 10, 0);
      send(2'd1, 1, 1, 20, 0);
      send(2'd2, 1, 1, 30, 0);
      send(2'd3, 1, 1, 40, 0);
      d0 = n_done;
      tick();
      rst = 1'b1;
      tick();
      check("t5_done",  64'(done), 64'd0);
      check("t5_score", best_score, 64'd0);
      check("t5_ready", 64'(cand_ready), 64'd0);
      check("t5_mode",  64'(best_mode), 64'd0);
      rst = 1'b0;
      idle(6);
      check("t5_no_late_done", 64'(n_done - d0), 64'd0);

      // Spectral distortion term, build dependent.
      pulse_start(16'd0);
      send(2'd0, 5, 5, 100, 50);
      send(2'd1, 0, 0, 1000, 0);
      send(2'd2, 0, 0, 1000, 0);
      send(2'd3, 0, 0, 1000, 0);
      wait_done(lat);
      check("t6_latency", 64'(lat), 64'd2);
      check("t6_mode", 64'(best_mode), 64'd0);
`ifdef UV_SD_EN
      check("t6_score", best_score, 64'd38400);
`else
      check("t6_score", best_score, 64'd25600);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
